// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port.
// Two sources (ALU result A, memory load M) share one registered write port
// under round-robin arbitration. A pending-write scoreboard lets the issue
// stage reserve destination registers and check operands for hazards.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic [NREG-1:0]   busy_vec,
  output logic [1:0]        err
);

  // ptr_m = 1 means M was not granted last and wins a tie
  logic              ptr_m;
  logic              grant_a;
  logic              grant_m;
  logic              grant;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic [NREG-1:0]   busy_nxt;
  logic              err0_hit;
  logic              err1_hit;

  // Round-robin grant from the valids and the pointer only
  always_comb begin
    grant_a = a_valid && (!m_valid || !ptr_m);
    grant_m = m_valid && !grant_a;
    grant   = grant_a || grant_m;
    g_addr  = grant_a ? a_addr : m_addr;
    g_data  = grant_a ? a_data : m_data;
  end

  assign a_ready = grant_a;
  assign m_ready = grant_m;
  assign rs_busy = busy_vec[rs_addr];
  assign rt_busy = busy_vec[rt_addr];

  // Scoreboard next state: commit clears, reservation sets and wins a tie
  always_comb begin
    busy_nxt = busy_vec;
    if (reg_write)
      busy_nxt[write_register] = 1'b0;
    if (rsv_valid && rsv_addr != '0)
      busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    err0_hit = rsv_valid && (rsv_addr != '0) && busy_vec[rsv_addr] &&
               !(reg_write && write_register == rsv_addr);
    err1_hit = grant && (g_addr != '0) && !busy_vec[g_addr];
  end

  // Registered write port and arbitration pointer; r0 writes are swallowed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_m          <= 1'b0;
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else begin
      reg_write <= grant && (g_addr != '0);
      if (grant) begin
        ptr_m <= grant_a;
        if (g_addr != '0) begin
          write_register <= g_addr;
          write_data     <= g_data;
        end
      end
    end
  end

  // Scoreboard and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec <= '0;
      err      <= 2'b00;
    end else begin
      busy_vec <= busy_nxt;
      if (err0_hit) err[0] <= 1'b1;
      if (err1_hit) err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbiter and scoreboard.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, m_valid = 1'b0, rsv_valid = 1'b0;
  logic [4:0]  a_addr = '0, m_addr = '0, rsv_addr = '0, rs_addr = '0, rt_addr = '0;
  logic [31:0] a_data = '0, m_data = '0;
  logic        a_ready, m_ready, rs_busy, rt_busy, reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] busy_vec;
  logic [1:0]  err;

  int nvec = 0;
  int nbad = 0;

  // Behavioural model state
  bit        mb[32];
  bit [1:0]  me;
  bit        mrw;
  bit [4:0]  mwr;
  bit [31:0] mwd;
  bit        mlast_a;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .busy_vec(busy_vec), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit exp_ga();
    if (a_valid && m_valid) return !mlast_a;
    return a_valid;
  endfunction

  function automatic bit exp_gm();
    if (a_valid && m_valid) return mlast_a;
    return m_valid;
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mb[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mb[i] = 1'b0;
    me = 2'b00; mrw = 1'b0; mwr = '0; mwd = '0; mlast_a = 1'b0;
  endtask

  // Apply the spec rules for one clock edge using the inputs now present
  task automatic model_step();
    bit nb[32];
    bit ga, gm;
    bit [4:0] ad;
    bit [31:0] dt;
    ga = exp_ga();
    gm = exp_gm();
    nb = mb;
    if (mrw) nb[mwr] = 1'b0;
    if (rsv_valid && rsv_addr != 0) begin
      if (mb[rsv_addr] && !(mrw && mwr == rsv_addr)) me[0] = 1'b1;
      nb[rsv_addr] = 1'b1;
    end
    if (ga || gm) begin
      ad = ga ? a_addr : m_addr;
      dt = ga ? a_data : m_data;
      if (ad != 0 && !mb[ad]) me[1] = 1'b1;
      mrw = (ad != 0);
      if (ad != 0) begin
        mwr = ad;
        mwd = dt;
      end
      mlast_a = ga;
    end else begin
      mrw = 1'b0;
    end
    nb[0] = 1'b0;
    mb = nb;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_valid = 0; m_valid = 0; rsv_valid = 0;
    a_addr = 0; m_addr = 0; rsv_addr = 0; rs_addr = 0; rt_addr = 0;
    a_data = 0; m_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    nvec++;
    if ({reg_write, write_register, write_data, busy_vec, err, a_ready, m_ready} !== '0) begin
      nbad++;
      $display("FAIL reset_state: got rw=%0b wr=%0d wd=%h busy=%h err=%b ar=%0b mr=%0b, want all 0",
               reg_write, write_register, write_data, busy_vec, err, a_ready, m_ready);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    rsv_valid = 1; rsv_addr = 5;
    cycle();
    rsv_valid = 0;
    a_valid = 1; a_addr = 5; a_data = 32'hDEAD_BEEF;
    cycle();
    a_valid = 0;
    #1;
    nvec++;
    if (reg_write !== 1'b1 || write_data !== 32'hDEAD_BEEF) begin
      nbad++;
      $display("FAIL midreset_pre: got rw=%0b wd=%h, want rw=1 wd=deadbeef", reg_write, write_data);
    end
    #1 rst = 1'b1;
    #1;
    nvec++;
    if ({reg_write, write_register, write_data, busy_vec, err} !== '0) begin
      nbad++;
      $display("FAIL midreset_async: got rw=%0b wr=%0d wd=%h busy=%h err=%b, want all 0",
               reg_write, write_register, write_data, busy_vec, err);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    rsv_valid = 1; rsv_addr = 5;
    cycle();
    rsv_valid = 0;
    cycle();
    a_valid = 1; a_addr = 5; a_data = 32'hDEAD_BEEF;
    #1;
    nvec++;
    if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
      nbad++;
      $display("FAIL single_ready: got a_ready=%0b m_ready=%0b, want 1 0", a_ready, m_ready);
    end
    cycle();
    a_valid = 0;
    #1;
    nvec++;
    if (reg_write !== 1'b1 || write_register !== 5'd5 || write_data !== 32'hDEAD_BEEF || busy_vec[5] !== 1'b1) begin
      nbad++;
      $display("FAIL single_write: got rw=%0b wr=%0d wd=%h busy5=%0b, want 1 5 deadbeef 1",
               reg_write, write_register, write_data, busy_vec[5]);
    end
    cycle();
    nvec++;
    if (reg_write !== 1'b0 || busy_vec !== 32'h0 || err !== 2'b00) begin
      nbad++;
      $display("FAIL single_after: got rw=%0b busy=%h err=%b, want 0 0 0", reg_write, busy_vec, err);
    end
  endtask

  task automatic test_contention();
    do_reset();
    rsv_valid = 1; rsv_addr = 3;
    cycle();
    rsv_addr = 4;
    cycle();
    rsv_valid = 0;
    a_valid = 1; a_addr = 3; a_data = 32'd1;
    m_valid = 1; m_addr = 4; m_data = 32'd2;
    #1;
    nvec++;
    if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
      nbad++;
      $display("FAIL contend_first: got a_ready=%0b m_ready=%0b, want 1 0", a_ready, m_ready);
    end
    cycle();
    rsv_valid = 1; rsv_addr = 3;   // re-reserve r3 on the edge its write commits
    #1;
    nvec++;
    if (a_ready !== 1'b0 || m_ready !== 1'b1 || reg_write !== 1'b1 || write_register !== 5'd3 || write_data !== 32'd1) begin
      nbad++;
      $display("FAIL contend_second: got ar=%0b mr=%0b rw=%0b wr=%0d wd=%h, want 0 1 1 3 1",
               a_ready, m_ready, reg_write, write_register, write_data);
    end
    cycle();
    rsv_valid = 0;
    m_valid = 0;
    #1;
    nvec++;
    if (a_ready !== 1'b1 || reg_write !== 1'b1 || write_register !== 5'd4 || write_data !== 32'd2 ||
        busy_vec !== 32'h18 || err !== 2'b00) begin
      nbad++;
      $display("FAIL contend_third: got ar=%0b rw=%0b wr=%0d wd=%h busy=%h err=%b, want 1 1 4 2 18 0",
               a_ready, reg_write, write_register, write_data, busy_vec, err);
    end
    cycle();
    a_valid = 0;
    nvec++;
    if (reg_write !== 1'b1 || write_register !== 5'd3 || busy_vec !== 32'h08) begin
      nbad++;
      $display("FAIL contend_fourth: got rw=%0b wr=%0d busy=%h, want 1 3 08", reg_write, write_register, busy_vec);
    end
    cycle();
    nvec++;
    if (reg_write !== 1'b0 || busy_vec !== 32'h0 || err !== 2'b00) begin
      nbad++;
      $display("FAIL contend_end: got rw=%0b busy=%h err=%b, want 0 0 0", reg_write, busy_vec, err);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    rsv_valid = 1; rsv_addr = 0;
    a_valid = 1; a_addr = 0; a_data = 32'h1234;
    rs_addr = 0; rt_addr = 0;
    #1;
    nvec++;
    if (a_ready !== 1'b1 || rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
      nbad++;
      $display("FAIL zero_ready: got ar=%0b rs_busy=%0b rt_busy=%0b, want 1 0 0", a_ready, rs_busy, rt_busy);
    end
    cycle();
    clear_inputs();
    #1;
    nvec++;
    if (reg_write !== 1'b0 || write_register !== 5'd0 || write_data !== 32'd0 || busy_vec !== 32'h0 || err !== 2'b00) begin
      nbad++;
      $display("FAIL zero_write: got rw=%0b wr=%0d wd=%h busy=%h err=%b, want 0 0 0 0 0",
               reg_write, write_register, write_data, busy_vec, err);
    end
  endtask

  task automatic test_errors();
    do_reset();
    rsv_valid = 1; rsv_addr = 7;
    cycle();
    cycle();
    rsv_valid = 0;
    rs_addr = 7; rt_addr = 9;
    #1;
    nvec++;
    if (err !== 2'b01 || rs_busy !== 1'b1 || rt_busy !== 1'b0) begin
      nbad++;
      $display("FAIL err_double_rsv: got err=%b rs_busy=%0b rt_busy=%0b, want 01 1 0", err, rs_busy, rt_busy);
    end
    m_valid = 1; m_addr = 9; m_data = 32'hCAFE_0009;
    cycle();
    m_valid = 0;
    nvec++;
    if (reg_write !== 1'b1 || write_register !== 5'd9 || write_data !== 32'hCAFE_0009 || err !== 2'b11) begin
      nbad++;
      $display("FAIL err_unreserved: got rw=%0b wr=%0d wd=%h err=%b, want 1 9 cafe0009 11",
               reg_write, write_register, write_data, err);
    end
    do_reset();
    rsv_valid = 1; rsv_addr = 6;
    cycle();
    rsv_valid = 0;
    a_valid = 1; a_addr = 6; a_data = 32'h66;
    cycle();
    a_valid = 0;
    rsv_valid = 1; rsv_addr = 6;
    cycle();
    rsv_valid = 0;
    nvec++;
    if (busy_vec[6] !== 1'b1 || err !== 2'b00 || reg_write !== 1'b0) begin
      nbad++;
      $display("FAIL err_same_edge: got busy6=%0b err=%b rw=%0b, want 1 00 0", busy_vec[6], err, reg_write);
    end
  endtask

  task automatic test_random();
    logic [75:0] obs, exp;
    bit a_hold = 0, m_hold = 0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (!a_hold) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_addr  = 5'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      if (!m_hold) begin
        m_valid = ($urandom_range(0, 2) != 0);
        m_addr  = 5'($urandom_range(0, 7));
        m_data  = $urandom;
      end
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = 5'($urandom_range(0, 7));
      rs_addr   = 5'($urandom_range(0, 7));
      rt_addr   = 5'($urandom_range(0, 7));
      #1;
      obs = {a_ready, m_ready, rs_busy, rt_busy, reg_write, write_register, write_data, busy_vec, err};
      exp = {exp_ga(), exp_gm(), mb[rs_addr], mb[rt_addr], mrw, mwr, mwd, exp_busy(), me};
      nvec++;
      if (obs !== exp) begin
        nbad++;
        $display("FAIL random[%0d]: got %h, want %h", n, obs, exp);
      end
      a_hold = a_valid && !exp_ga();
      m_hold = m_valid && !exp_gm();
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_single_write();
    test_contention();
    test_zero_reg();
    test_errors();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the ALU result path (A) and the memory-load path (M).
- Round-robin arbitration with valid/ready handshakes.
- Write port outputs are registered.
- Keeps a per-register pending-write scoreboard. The issue stage reserves destinations in it and queries it for source-operand hazards.
- Sits between the execute/memory stages and the register file write inputs (reg_write, write_register, write_data).

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register address width
NREG, 32, number of registers (2**ADDR_W)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; asynchronous, active-high
a_valid  in  1  ALU writeback request
a_ready  out  1  ALU request accepted this cycle (combinational)
a_addr  in  ADDR_W  ALU destination register
a_data  in  DATA_W  ALU result
m_valid  in  1  memory writeback request
m_ready  out  1  memory request accepted this cycle (combinational)
m_addr  in  ADDR_W  load destination register
m_data  in  DATA_W  load data
rsv_valid  in  1  issue stage reserves a destination register
rsv_addr  in  ADDR_W  register being reserved
rs_addr  in  ADDR_W  source operand 1 query
rt_addr  in  ADDR_W  source operand 2 query
rs_busy  out  1  rs_addr has a pending write (combinational)
rt_busy  out  1  rt_addr has a pending write (combinational)
reg_write  out  1  write enable to register file (registered)
write_register  out  ADDR_W  write address (registered)
write_data  out  DATA_W  write data (registered)
busy_vec  out  NREG  scoreboard, bit i = register i pending
err  out  2  sticky: [0] reservation of an already-busy register, [1] write to an unreserved nonzero register

Behaviour:
- Reset (async, rst=1): reg_write=0, write_register=0, write_data=0, busy_vec=0, err=0, round-robin pointer favours A. A write held in the output register is dropped and never reaches the register file.
- Arbitration:
  - At most one grant per cycle; the port is never idle while any request is valid.
  - Only A valid: a_ready=1. Only M valid: m_ready=1.
  - Both valid: grant the source not granted last; the pointer updates only on an actual grant.
  - a_ready/m_ready depend only on a_valid, m_valid and the pointer, never on the ready outputs.
  - A requester holds valid, addr and data stable until ready.
- Write port, latency 1: on the edge where a grant occurs, load write_register/write_data from the granted source and set reg_write=1 for exactly that following cycle. reg_write=0 in any cycle after a no-grant edge. Back-to-back grants give reg_write=1 on consecutive cycles.
- Register 0:
  - Granted requests to addr 0 are accepted (ready=1) but produce reg_write=0, and write_register/write_data hold their previous values.
  - rsv_addr=0 is ignored.
  - rs_busy/rt_busy are 0 for address 0; busy_vec[0] is always 0.
- Scoreboard:
  - Set: rsv_valid and rsv_addr!=0 set busy_vec[rsv_addr] on the clock edge.
  - Clear: busy_vec[write_register] clears on the edge ending a cycle with reg_write=1, i.e. the same edge the register file commits the data. busy stays 1 while reg_write=1 is presented.
  - Same address set and cleared on the same edge: set wins (result 1).
- rs_busy = busy_vec[rs_addr], rt_busy = busy_vec[rt_addr], combinational from registered state.
- Errors:
  - err[0] sets when rsv_valid, rsv_addr!=0 and busy_vec[rsv_addr]=1 before the edge, unless that same edge also clears the bit.
  - err[1] sets when a grant to a nonzero addr finds its busy bit 0 at grant time; the write still proceeds.
  - Both bits stay set until rst.

Test Plan:
- Reset mid-write: rsv r5; A writes r5=0xDEAD_BEEF and grant edge occurs; assert rst asynchronously while reg_write=1 -> reg_write, write_register, write_data, busy_vec and err drop to 0 immediately, before the next clock edge.
- Single write: rsv r5 at cycle 0; A valid r5=0xDEAD_BEEF at cycle 2 -> a_ready=1 at cycle 2; reg_write=1, write_register=5, write_data=0xDEADBEEF at cycle 3; busy_vec[5]=1 through cycle 3, 0 at cycle 4; err=0.
- Contention: rsv r3 and r4; A (r3=1) and M (r4=2) both valid for 3 cycles after reset -> grants A, M in that order, A's second request waits; reg_write sequence r3=1 then r4=2; busy bits clear one per cycle.
- Zero register: A writes r0=0x1234 -> a_ready=1, reg_write stays 0, err=0; rs_addr=0 -> rs_busy=0.
- Hazards/errors: rsv r7 twice with no intervening write -> err[0]=1. M writes r9 with no reservation -> write performed, err[1]=1. Same-edge rsv r6 and write-commit of r6 -> busy_vec[6]=1, err[0]=0.
